// File: rtl/bpu_btb_pkg.sv
// bpu_btb shared definitions: counter encodings, reset PC,
// default geometry and entry-field width helpers.
package bpu_btb_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [31:0] BPU_RESET_PC = 32'h8000_0000;

  localparam int BPU_ADDR_W  = 32;
  localparam int BPU_ENTRIES = 16;
  localparam int BPU_CTR_W   = 2;

  function automatic int bpu_idx_w(int entries);
    return $clog2(entries);
  endfunction

  function automatic int bpu_tag_w(int addr_w, int entries);
    return addr_w - $clog2(entries) - 2;
  endfunction

endpackage

// File: rtl/bpu_btb_sat_counter.sv
// Saturating up/down counter next-value function.
// Pure combinational; clamps at zero and all-ones.
module sat_counter #(
  parameter int W = 2
) (
  input  logic [W-1:0] ctr,
  input  logic         inc,
  output logic [W-1:0] nxt
);

  // step toward taken/not-taken without wrapping
  always_comb begin
    nxt = ctr;
    if (inc) begin
      if (ctr != {W{1'b1}}) nxt = ctr + W'(1);
    end else begin
      if (ctr != {W{1'b0}}) nxt = ctr - W'(1);
    end
  end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with 2-bit counters and registered redirect.
// Optional perf counters: define BPU_PERF_COUNTERS_EN.
module bpu_btb
  import bpu_btb_pkg::*;
#(
  parameter int ADDR_W  = BPU_ADDR_W,
  parameter int ENTRIES = BPU_ENTRIES,
  parameter int CTR_W   = BPU_CTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(BPU_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              pred_taken_o,
  output logic [ADDR_W-1:0] pred_target_o,
  input  logic              upd_valid_i,
  input  logic [ADDR_W-1:0] upd_pc_i,
  input  logic              upd_is_cond_i,
  input  logic              upd_is_jump_i,
  input  logic              upd_taken_i,
  input  logic [ADDR_W-1:0] upd_target_i,
  input  logic              upd_pred_taken_i,
  input  logic [ADDR_W-1:0] upd_pred_target_i,
  output logic              mispredict_o,
  output logic [ADDR_W-1:0] redirect_pc_o
`ifdef BPU_PERF_COUNTERS_EN
  ,
  output logic [31:0]       perf_lookups_o,
  output logic [31:0]       perf_mispredicts_o
`endif
);

  localparam int IDX_W = bpu_idx_w(ENTRIES);
  localparam int TAG_W = bpu_tag_w(ADDR_W, ENTRIES);

  localparam logic [CTR_W-1:0] CTR_INIT  = CTR_W'(CTR_WNT);
  localparam logic [CTR_W-1:0] CTR_ALLOC = CTR_W'(1) << (CTR_W - 1);

  logic              valid_q [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic              jmp_q   [ENTRIES];
  logic [CTR_W-1:0]  ctr_q   [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;

  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic              up_ctrl;
  logic              up_misp;
  logic [CTR_W-1:0]  ctr_nxt;

  assign lk_idx = lookup_pc_i[IDX_W+1:2];
  assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
  assign up_idx = upd_pc_i[IDX_W+1:2];
  assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];

  // lookup: read-before-write, forced not-taken in reset
  always_comb begin
    lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken_o  = !rst && lk_hit &&
                    (jmp_q[lk_idx] || ctr_q[lk_idx][CTR_W-1]);
    pred_target_o = pred_taken_o ? tgt_q[lk_idx]
                                 : lookup_pc_i + ADDR_W'(4);
  end

  // classify the resolved instruction and detect mispredicts
  always_comb begin
    up_ctrl = upd_valid_i && (upd_is_cond_i || upd_is_jump_i);
    up_hit  = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    up_misp = up_ctrl &&
              ((upd_pred_taken_i != upd_taken_i) ||
               (upd_taken_i && upd_pred_target_i != upd_target_i));
  end

  sat_counter #(.W(CTR_W)) u_ctr (
    .ctr (ctr_q[up_idx]),
    .inc (upd_taken_i),
    .nxt (ctr_nxt)
  );

  // table write: train on hit, allocate on taken miss
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        jmp_q[i]   <= 1'b0;
        ctr_q[i]   <= CTR_INIT;
      end
    end else if (up_ctrl) begin
      if (up_hit) begin
        if (upd_is_cond_i) begin
          ctr_q[up_idx] <= ctr_nxt;
          if (upd_taken_i) tgt_q[up_idx] <= upd_target_i;
        end
        if (upd_is_jump_i) begin
          tgt_q[up_idx] <= upd_target_i;
          jmp_q[up_idx] <= 1'b1;
        end
      end else if (upd_taken_i) begin
        valid_q[up_idx] <= 1'b1;
        tag_q[up_idx]   <= up_tag;
        tgt_q[up_idx]   <= upd_target_i;
        jmp_q[up_idx]   <= upd_is_jump_i;
        ctr_q[up_idx]   <= CTR_ALLOC;
      end
    end
  end

  // one-cycle redirect pulse; target held between pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_o  <= 1'b0;
      redirect_pc_o <= RESET_PC;
    end else begin
      mispredict_o <= up_misp;
      if (up_misp)
        redirect_pc_o <= upd_taken_i ? upd_target_i
                                     : upd_pc_i + ADDR_W'(4);
    end
  end

`ifdef BPU_PERF_COUNTERS_EN
  // free-running event counters, wrap at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lookups_o     <= '0;
      perf_mispredicts_o <= '0;
    end else begin
      if (up_ctrl) perf_lookups_o     <= perf_lookups_o + 32'd1;
      if (up_misp) perf_mispredicts_o <= perf_mispredicts_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_btb.sv
// Self-checking bench for bpu_btb: reference model plus
// directed vectors with literal expectations.
module tb_bpu_btb;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_is_cond;
  logic        upd_is_jump;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;

  int checks   = 0;
  int failures = 0;
  bit run_cmp  = 1'b0;

  always #5 clk = ~clk;

  bpu_btb dut (
    .clk               (clk),
    .rst               (rst),
    .lookup_pc_i       (lookup_pc),
    .pred_taken_o      (pred_taken),
    .pred_target_o     (pred_target),
    .upd_valid_i       (upd_valid),
    .upd_pc_i          (upd_pc),
    .upd_is_cond_i     (upd_is_cond),
    .upd_is_jump_i     (upd_is_jump),
    .upd_taken_i       (upd_taken),
    .upd_target_i      (upd_target),
    .upd_pred_taken_i  (upd_pred_taken),
    .upd_pred_target_i (upd_pred_target),
    .mispredict_o      (mispredict),
    .redirect_pc_o     (redirect_pc)
  );

  // reference model state, indexed by (pc/4) mod 16
  bit          m_valid [16];
  int unsigned m_tagv  [16];
  logic [31:0] m_tgt   [16];
  bit          m_jmp   [16];
  int          m_ctr   [16];
  bit          m_misp;
  logic [31:0] m_redir;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_tagv[i]  = 0;
      m_tgt[i]   = '0;
      m_jmp[i]   = 1'b0;
      m_ctr[i]   = 1;
    end
    m_misp  = 1'b0;
    m_redir = 32'h8000_0000;
  endtask

  function automatic void predict(input logic [31:0] pc,
                                  output logic t,
                                  output logic [31:0] tg);
    int idx;
    bit hit;
    idx = int'((pc / 4) % 16);
    hit = m_valid[idx] && (m_tagv[idx] == pc / 64);
    t   = !rst && hit && (m_jmp[idx] || m_ctr[idx] >= 2);
    tg  = t ? m_tgt[idx] : pc + 32'd4;
  endfunction

  // applies one clock edge worth of update to the model
  task automatic model_step();
    int idx;
    bit hit, ctrl, wrong;
    if (rst) return;
    idx   = int'((upd_pc / 4) % 16);
    hit   = m_valid[idx] && (m_tagv[idx] == upd_pc / 64);
    ctrl  = upd_valid && (upd_is_cond || upd_is_jump);
    wrong = (upd_pred_taken != upd_taken) ||
            (upd_taken && upd_pred_target != upd_target);
    m_misp = ctrl && wrong;
    if (m_misp) m_redir = upd_taken ? upd_target : upd_pc + 32'd4;
    if (!ctrl) return;
    if (hit) begin
      if (upd_is_cond) begin
        if (upd_taken) begin
          if (m_ctr[idx] < 3) m_ctr[idx]++;
          m_tgt[idx] = upd_target;
        end else if (m_ctr[idx] > 0) begin
          m_ctr[idx]--;
        end
      end
      if (upd_is_jump) begin
        m_tgt[idx] = upd_target;
        m_jmp[idx] = 1'b1;
      end
    end else if (upd_taken) begin
      m_valid[idx] = 1'b1;
      m_tagv[idx]  = upd_pc / 64;
      m_tgt[idx]   = upd_target;
      m_jmp[idx]   = upd_is_jump;
      m_ctr[idx]   = 2;
    end
  endtask

  // compare every output against the model each cycle
  always @(negedge clk) begin
    logic        et;
    logic [31:0] etg;
    if (run_cmp) begin
      predict(lookup_pc, et, etg);
      chk("cyc_pred_taken", {31'd0, pred_taken}, {31'd0, et});
      chk("cyc_pred_target", pred_target, etg);
      chk("cyc_mispredict", {31'd0, mispredict}, {31'd0, m_misp});
      chk("cyc_redirect_pc", redirect_pc, m_redir);
    end
  end

  task automatic tick();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic upd(input logic [31:0] pc, input bit c, input bit j,
                     input bit t, input logic [31:0] tg,
                     input bit pt, input logic [31:0] ptg);
    upd_valid       = 1'b1;
    upd_pc          = pc;
    upd_is_cond     = c;
    upd_is_jump     = j;
    upd_taken       = t;
    upd_target      = tg;
    upd_pred_taken  = pt;
    upd_pred_target = ptg;
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    lookup_pc = 32'h8000_0010;
    upd_valid = 1'b0;
    upd_pc = '0;
    upd_is_cond = 1'b0;
    upd_is_jump = 1'b0;
    upd_taken = 1'b0;
    upd_target = '0;
    upd_pred_taken = 1'b0;
    upd_pred_target = '0;
    #1 rst = 1'b1;
    model_reset();
    run_cmp = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // reset state
    look(32'h8000_0010);
    chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("rst_pred_target", pred_target, 32'h8000_0014);
    chk("rst_redirect", redirect_pc, 32'h8000_0000);
    chk("rst_misp", {31'd0, mispredict}, 32'd0);

    // taken branch miss: allocate weakly taken, redirect
    upd(32'h8000_0010, 1, 0, 1, 32'h8000_0040, 0, 32'h8000_0014);
    chk("alloc_misp", {31'd0, mispredict}, 32'd1);
    chk("alloc_redirect", redirect_pc, 32'h8000_0040);
    chk("alloc_pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("alloc_pred_target", pred_target, 32'h8000_0040);
    tick();
    chk("pulse_one_cycle", {31'd0, mispredict}, 32'd0);
    chk("redirect_held", redirect_pc, 32'h8000_0040);

    // not-taken training: 10 -> 01 -> 00 -> 00
    upd(32'h8000_0010, 1, 0, 0, 32'h8000_0040, 1, 32'h8000_0040);
    chk("nt1_misp", {31'd0, mispredict}, 32'd1);
    chk("nt1_redirect", redirect_pc, 32'h8000_0014);
    chk("nt1_pred_taken", {31'd0, pred_taken}, 32'd0);
    upd(32'h8000_0010, 1, 0, 0, 32'h8000_0040, 0, 32'h8000_0014);
    upd(32'h8000_0010, 1, 0, 0, 32'h8000_0040, 0, 32'h8000_0014);
    chk("nt3_misp", {31'd0, mispredict}, 32'd0);
    upd(32'h8000_0010, 1, 0, 1, 32'h8000_0040, 0, 32'h8000_0014);
    chk("sat_t_misp", {31'd0, mispredict}, 32'd1);
    chk("sat_t_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("sat_t_pred_target", pred_target, 32'h8000_0014);

    // JALR with wrong predicted target
    look(32'h8000_0100);
    upd(32'h8000_0100, 0, 1, 1, 32'h8000_0300, 1, 32'h8000_0200);
    chk("jalr_misp", {31'd0, mispredict}, 32'd1);
    chk("jalr_redirect", redirect_pc, 32'h8000_0300);
    chk("jalr_pred_taken", {31'd0, pred_taken}, 32'd1);
    chk("jalr_pred_target", pred_target, 32'h8000_0300);
    upd(32'h8000_0100, 0, 1, 1, 32'h8000_0300, 1, 32'h8000_0300);
    chk("jalr_ok_misp", {31'd0, mispredict}, 32'd0);
    upd(32'h8000_0100, 0, 1, 1, 32'h8000_0400, 1, 32'h8000_0300);
    chk("jalr_new_redirect", redirect_pc, 32'h8000_0400);
    chk("jalr_new_target", pred_target, 32'h8000_0400);

    // aliasing: 0x50 shares index with 0x10
    upd(32'h8000_0050, 1, 0, 1, 32'h8000_0080, 0, 32'h8000_0054);
    look(32'h8000_0010);
    chk("alias_old_taken", {31'd0, pred_taken}, 32'd0);
    chk("alias_old_target", pred_target, 32'h8000_0014);
    look(32'h8000_0050);
    chk("alias_new_taken", {31'd0, pred_taken}, 32'd1);
    chk("alias_new_target", pred_target, 32'h8000_0080);

    // non-control update never redirects
    upd(32'h8000_0050, 0, 0, 1, 32'h1234_5678, 0, 32'h8000_0054);
    chk("nonctrl_misp", {31'd0, mispredict}, 32'd0);
    chk("nonctrl_redirect", redirect_pc, 32'h8000_0080);

    // fall-through wraps at 2^32
    look(32'hFFFF_FFFC);
    chk("wrap_target", pred_target, 32'h0000_0000);
    tick();

    // async reset mid-cycle with an update pending
    look(32'h8000_0050);
    upd_valid       = 1'b1;
    upd_pc          = 32'h8000_0200;
    upd_is_cond     = 1'b0;
    upd_is_jump     = 1'b1;
    upd_taken       = 1'b1;
    upd_target      = 32'h8000_0500;
    upd_pred_taken  = 1'b0;
    upd_pred_target = 32'h8000_0204;
    #1 rst = 1'b1;
    model_reset();
    #1;
    chk("mrst_misp", {31'd0, mispredict}, 32'd0);
    chk("mrst_redirect", redirect_pc, 32'h8000_0000);
    chk("mrst_pred_taken", {31'd0, pred_taken}, 32'd0);
    chk("mrst_pred_target", pred_target, 32'h8000_0054);
    tick();
    rst = 1'b0;
    upd_valid = 1'b0;
    tick();
    look(32'h8000_0200);
    chk("mrst_nowrite_taken", {31'd0, pred_taken}, 32'd0);
    chk("mrst_nowrite_target", pred_target, 32'h8000_0204);
    chk("mrst_after_misp", {31'd0, mispredict}, 32'd0);
    look(32'h8000_0050);
    chk("mrst_cleared", {31'd0, pred_taken}, 32'd0);
    tick();
    tick();

    run_cmp = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpu_btb.md
Name: bpu_btb

Overview:
- Dynamic branch predictor for the RV32 core.
- Queried combinationally by the IFU with the fetch PC; returns a predicted-taken flag and a target from a direct-mapped BTB with 2-bit saturating counters.
- Updated by IDU branch resolution with the resolved direction and target.
- Produces a registered mispredict/redirect pulse, one cycle after the update, that steers the PC register.

Parameters:
- ADDR_W, 32, instruction address width.
- ENTRIES, 16, BTB/BHT depth; power of two, at least 2.
- CTR_W, 2, saturating counter width.
- RESET_PC, 32'h8000_0000, redirect_pc_o value while in reset.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; asynchronous, active-high
- lookup_pc_i  in  ADDR_W  fetch PC
- pred_taken_o  out  1  predicted taken for lookup_pc_i (combinational)
- pred_target_o  out  ADDR_W  predicted next PC: target if taken, else lookup_pc_i+4 (combinational)
- upd_valid_i  in  1  resolution valid this cycle
- upd_pc_i  in  ADDR_W  PC of the resolved instruction
- upd_is_cond_i  in  1  conditional branch (BEQ..BGEU)
- upd_is_jump_i  in  1  JAL/JALR
- upd_taken_i  in  1  resolved taken (branch_en)
- upd_target_i  in  ADDR_W  resolved taken target
- upd_pred_taken_i  in  1  prediction made at fetch, carried down the pipe
- upd_pred_target_i  in  ADDR_W  predicted next PC carried down the pipe
- mispredict_o  out  1  one-cycle redirect pulse (registered)
- redirect_pc_o  out  ADDR_W  correct next PC (registered)

Behaviour:
- Entry fields:
  - valid
  - tag = pc[ADDR_W-1 : IDX_W+2], with IDX_W = log2(ENTRIES)
  - target
  - jump flag
  - counter
- Index is pc[IDX_W+1:2]. hit = valid && tag match.
- Lookup: pred_taken_o = hit && (jump || counter MSB). pred_target_o = pred_taken_o ? target : lookup_pc_i + 4, with 32-bit wraparound.
- Update: applies at the clk edge when upd_valid_i && (upd_is_cond_i || upd_is_jump_i). Non-control updates are ignored and never raise a mispredict.
  - Hit, conditional: counter increments on taken, decrements on not taken; saturates at all-ones and zero. Target rewritten on taken.
  - Hit, jump: target rewritten; jump flag set.
  - Miss, taken: allocate (overwrite). valid=1, new tag and target, jump=upd_is_jump_i, counter = 2'b10 (weakly taken).
  - Miss, not taken: no allocation.
- Mispredict: raised when upd_pred_taken_i != upd_taken_i, or both are taken and upd_pred_target_i != upd_target_i.
  - Latched at the same edge as the table update.
  - mispredict_o is high for exactly 1 cycle.
  - redirect_pc_o = upd_taken_i ? upd_target_i : upd_pc_i + 4. It holds its last value when there is no mispredict.
- Same-cycle lookup and update to the same index: lookup returns pre-update contents; there is no bypass.
- Back-to-back updates to the same entry accumulate every cycle.
- Reset, asynchronous and valid even mid-update:
  - all valid bits cleared, counters = 2'b01
  - mispredict_o = 0, redirect_pc_o = RESET_PC
  - while rst is high, pred_taken_o = 0 and pred_target_o = lookup_pc_i + 4
- Update inputs are sampled only when rst is low.

Optional Feature:
- Macro: BPU_PERF_COUNTERS_EN.
- When defined, the block adds:
  - perf_lookups_o, 32-bit: counts control updates
  - perf_mispredicts_o, 32-bit: counts mispredict pulses
- Both counters reset to 0, wrap at 2^32, and increment at the same edge as the table write.
- When undefined, these ports and registers are absent, with no other behavioural change.

Decomposition:
- Shared defines file holds:
  - counter encodings CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11
  - RESET_PC
  - BPU entry-field width macros
- Sub-module sat_counter: pure-combinational CTR_W-bit saturating next-value function, instantiated on the update path.
- Table storage, lookup mux and redirect register stay in bpu_btb.

Test Plan:
- Reset then lookup 0x8000_0010 -> pred_taken_o=0, pred_target_o=0x8000_0014; redirect_pc_o=0x8000_0000, mispredict_o=0.
- Update pc=0x8000_0010, cond, taken, target 0x8000_0040, pred_taken=0 -> next cycle mispredict_o=1 for 1 cycle, redirect_pc_o=0x8000_0040. Lookup 0x8000_0010 then predicts taken to 0x8000_0040.
- Three not-taken updates on that entry (counter 10→01→00→00) -> prediction flips to not-taken after the first update. Counter saturates at 00; a single taken update then gives 01, still not-taken.
- JALR update pc=0x8000_0100, pred target 0x8000_0200, actual 0x8000_0300 -> mispredict_o=1, redirect_pc_o=0x8000_0300. Entry target updated; jump entry is always predicted taken.
- Aliasing with ENTRIES=16: update 0x8000_0010, then 0x8000_0050 (same index, different tag), taken -> the second allocation overwrites the first. Lookup of 0x8000_0010 misses.
- Assert rst mid-cycle with upd_valid_i high -> all outputs return to reset values immediately, and no entry is written.
